// File: rtl/link_table_queue_ctrl_pkg.sv
// Shared definitions for the linked-list queue controller: read FSM states,
// default geometry and the bit layout of the combined data/link RAM read word.
package link_table_queue_ctrl_pkg;

    localparam int DEF_DATA_WIDTH        = 8;
    localparam int DEF_ADDR_PAGE_NUM_LOG = 4;

    typedef enum logic [1:0] {
        RD_IDLE  = 2'd0,
        RD_FETCH = 2'd1,
        RD_LOAD  = 2'd2,
        RD_VALID = 2'd3
    } rd_state_e;

    // Read word layout is {eop, data, next}, next pointer in the low bits.
    localparam int RAM_NEXT_LSB = 0;

    function automatic int ram_data_lsb(input int aw);
        return aw;
    endfunction

    function automatic int ram_eop_bit(input int aw, input int dw);
        return aw + dw;
    endfunction

endpackage

// File: rtl/link_table_queue_ctrl_if.sv
// Write and read word streams of the queue controller (valid/ready on both sides).
interface link_table_queue_ctrl_if #(
    parameter int DATA_WIDTH = 8
);
    logic                  wr_valid;
    logic [DATA_WIDTH-1:0] wr_data;
    logic                  wr_eop;
    logic                  wr_ready;

    logic                  rd_valid;
    logic [DATA_WIDTH-1:0] rd_data;
    logic                  rd_sop;
    logic                  rd_eop;
    logic                  rd_ready;

    modport master (
        output wr_valid, wr_data, wr_eop,
        input  wr_ready,
        input  rd_valid, rd_data, rd_sop, rd_eop,
        output rd_ready
    );

    modport slave (
        input  wr_valid, wr_data, wr_eop,
        output wr_ready,
        output rd_valid, rd_data, rd_sop, rd_eop,
        input  rd_ready
    );
endinterface

// File: rtl/link_table_rd_walker.sv
// Read side of the queue: walks the list from head, holds the current word for the
// consumer and tracks the successor pointer, including links written while in flight.
module link_table_rd_walker
    import link_table_queue_ctrl_pkg::*;
#(
    parameter int DATA_WIDTH        = DEF_DATA_WIDTH,
    parameter int ADDR_PAGE_NUM_LOG = DEF_ADDR_PAGE_NUM_LOG
) (
    input  logic                                      clk,
    input  logic                                      rst_n,
    input  logic [ADDR_PAGE_NUM_LOG:0]                word_cnt,
    input  logic                                      wr_fire,
    input  logic [ADDR_PAGE_NUM_LOG-1:0]              head,
    input  logic                                      link_wr_en,
    input  logic [ADDR_PAGE_NUM_LOG-1:0]              link_wr_addr,
    input  logic [ADDR_PAGE_NUM_LOG-1:0]              link_wr_data,
    output logic                                      ram_rd_en,
    output logic [ADDR_PAGE_NUM_LOG-1:0]              ram_rd_addr,
    input  logic [DATA_WIDTH+ADDR_PAGE_NUM_LOG:0]     ram_rd_data,
    output logic                                      rd_valid,
    output logic [DATA_WIDTH-1:0]                     rd_data,
    output logic                                      rd_sop,
    output logic                                      rd_eop,
    input  logic                                      rd_ready,
    output logic                                      rd_fire,
    output logic [ADDR_PAGE_NUM_LOG-1:0]              head_nxt
);
    localparam int DW       = DATA_WIDTH;
    localparam int AW       = ADDR_PAGE_NUM_LOG;
    localparam int CW2      = AW + 2;
    localparam int DATA_LSB = ram_data_lsb(AW);
    localparam int EOP_BIT  = ram_eop_bit(AW, DW);

    rd_state_e      state_q, state_d;
    logic [DW-1:0]  rd_data_q, rd_data_d;
    logic           rd_eop_q, rd_eop_d;
    logic [AW-1:0]  next_ptr_q, next_ptr_d;
    logic           byp_q, byp_d;
    logic           sop_q, sop_d;
    logic           link_hit;
    logic [CW2-1:0] cnt_after;

    assign link_hit  = link_wr_en && (link_wr_addr == head);
    assign rd_fire   = (state_q == RD_VALID) && rd_ready;
    assign cnt_after = {1'b0, word_cnt} + CW2'(wr_fire) - CW2'(1'b1);
    // A link written to the current head this cycle wins over the stored successor.
    assign head_nxt  = link_hit ? link_wr_data : next_ptr_q;

    always_comb begin
        // NOTE: every output of this block gets a default first, so no path infers a latch.
        state_d     = state_q;
        rd_data_d   = rd_data_q;
        rd_eop_d    = rd_eop_q;
        next_ptr_d  = next_ptr_q;
        byp_d       = byp_q;
        sop_d       = sop_q;
        ram_rd_en   = 1'b0;
        ram_rd_addr = '0;
        unique case (state_q)
            RD_IDLE: begin
                if (word_cnt != '0) state_d = RD_FETCH;
            end
            RD_FETCH: begin
                ram_rd_en   = 1'b1;
                ram_rd_addr = head;
                // The RAM returns the pre-write link, so remember a link landing now.
                byp_d       = link_hit;
                if (link_hit) next_ptr_d = link_wr_data;
                state_d     = RD_LOAD;
            end
            RD_LOAD: begin
                rd_data_d = ram_rd_data[DATA_LSB +: DW];
                rd_eop_d  = ram_rd_data[EOP_BIT];
                if (link_hit)   next_ptr_d = link_wr_data;
                else if (!byp_q) next_ptr_d = ram_rd_data[RAM_NEXT_LSB +: AW];
                state_d   = RD_VALID;
            end
            RD_VALID: begin
                if (link_hit) next_ptr_d = link_wr_data;
                if (rd_fire) begin
                    sop_d   = rd_eop_q;
                    state_d = (cnt_after != '0) ? RD_FETCH : RD_IDLE;
                end
            end
            default: state_d = RD_IDLE;
        endcase
    end

    // NOTE: state registers use non-blocking assignments so all flops update together.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= RD_IDLE;
            rd_data_q  <= '0;
            rd_eop_q   <= 1'b0;
            next_ptr_q <= '0;
            byp_q      <= 1'b0;
            sop_q      <= 1'b1;
        end else begin
            state_q    <= state_d;
            rd_data_q  <= rd_data_d;
            rd_eop_q   <= rd_eop_d;
            next_ptr_q <= next_ptr_d;
            byp_q      <= byp_d;
            sop_q      <= sop_d;
        end
    end

    assign rd_valid = (state_q == RD_VALID);
    assign rd_data  = rd_data_q;
    assign rd_eop   = rd_eop_q;
    // The start-of-packet flag idles high; it is only shown alongside a valid word.
    assign rd_sop   = rd_valid & sop_q;

endmodule

// File: rtl/link_table_queue_ctrl.sv
// Single-queue linked-list packet store sequencer: the writer takes one free page per
// word and links it behind the tail; the read walker streams words out from head.
module link_table_queue_ctrl
    import link_table_queue_ctrl_pkg::*;
#(
    parameter int DATA_WIDTH        = DEF_DATA_WIDTH,
    parameter int ADDR_PAGE_NUM_LOG = DEF_ADDR_PAGE_NUM_LOG
) (
    input  logic                                  clk,
    input  logic                                  rst_n,
    link_table_queue_ctrl_if.slave                stream,
    output logic                                  free_table_read_req,
    input  logic [ADDR_PAGE_NUM_LOG-1:0]          free_table_read_addr,
    input  logic                                  free_table_empty,
    output logic                                  free_table_write_req,
    output logic [ADDR_PAGE_NUM_LOG-1:0]          free_table_write_addr,
    output logic                                  ram_wr_en,
    output logic [ADDR_PAGE_NUM_LOG-1:0]          ram_wr_addr,
    output logic [DATA_WIDTH:0]                   ram_wr_data,
    output logic                                  link_wr_en,
    output logic [ADDR_PAGE_NUM_LOG-1:0]          link_wr_addr,
    output logic [ADDR_PAGE_NUM_LOG-1:0]          link_wr_data,
    output logic                                  ram_rd_en,
    output logic [ADDR_PAGE_NUM_LOG-1:0]          ram_rd_addr,
    input  logic [DATA_WIDTH+ADDR_PAGE_NUM_LOG:0] ram_rd_data,
    output logic [ADDR_PAGE_NUM_LOG:0]            word_cnt,
    output logic [ADDR_PAGE_NUM_LOG:0]            pkt_cnt
);
    localparam int DW = DATA_WIDTH;
    localparam int AW = ADDR_PAGE_NUM_LOG;
    localparam int CW = AW + 1;

    logic          wr_fire, rd_fire, rd_eop_w;
    logic          rd_valid_w, rd_sop_w;
    logic [DW-1:0] rd_data_w;
    logic [AW-1:0] head_q, head_d, tail_q, tail_d, head_nxt;
    logic [CW-1:0] word_cnt_q, word_cnt_d, pkt_cnt_q, pkt_cnt_d, word_cnt_eff;

    assign stream.wr_ready = ~free_table_empty;
    assign wr_fire         = stream.wr_valid & ~free_table_empty;
    // Occupancy as seen by the writer once a same-cycle read has left.
    assign word_cnt_eff    = word_cnt_q - CW'(rd_fire);

    assign free_table_read_req   = wr_fire;
    assign free_table_write_req  = rd_fire;
    assign free_table_write_addr = rd_fire ? head_q : '0;

    assign ram_wr_en    = wr_fire;
    assign ram_wr_addr  = wr_fire ? free_table_read_addr : '0;
    assign ram_wr_data  = wr_fire ? {stream.wr_eop, stream.wr_data} : '0;

    // A word entering an (effectively) empty queue becomes head; otherwise it hangs off tail.
    assign link_wr_en   = wr_fire && (word_cnt_eff != '0);
    assign link_wr_addr = link_wr_en ? tail_q : '0;
    assign link_wr_data = link_wr_en ? free_table_read_addr : '0;

    always_comb begin
        head_d     = head_q;
        tail_d     = tail_q;
        word_cnt_d = word_cnt_q + CW'(wr_fire) - CW'(rd_fire);
        pkt_cnt_d  = pkt_cnt_q + CW'(wr_fire & stream.wr_eop) - CW'(rd_fire & rd_eop_w);
        if (rd_fire) head_d = head_nxt;
        if (wr_fire) begin
            tail_d = free_table_read_addr;
            if (word_cnt_eff == '0) head_d = free_table_read_addr;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            head_q     <= '0;
            tail_q     <= '0;
            word_cnt_q <= '0;
            pkt_cnt_q  <= '0;
        end else begin
            head_q     <= head_d;
            tail_q     <= tail_d;
            word_cnt_q <= word_cnt_d;
            pkt_cnt_q  <= pkt_cnt_d;
        end
    end

    link_table_rd_walker #(
        .DATA_WIDTH        (DW),
        .ADDR_PAGE_NUM_LOG (AW)
    ) u_rd_walker (
        .clk          (clk),
        .rst_n        (rst_n),
        .word_cnt     (word_cnt_q),
        .wr_fire      (wr_fire),
        .head         (head_q),
        .link_wr_en   (link_wr_en),
        .link_wr_addr (link_wr_addr),
        .link_wr_data (link_wr_data),
        .ram_rd_en    (ram_rd_en),
        .ram_rd_addr  (ram_rd_addr),
        .ram_rd_data  (ram_rd_data),
        .rd_valid     (rd_valid_w),
        .rd_data      (rd_data_w),
        .rd_sop       (rd_sop_w),
        .rd_eop       (rd_eop_w),
        .rd_ready     (stream.rd_ready),
        .rd_fire      (rd_fire),
        .head_nxt     (head_nxt)
    );

    assign stream.rd_valid = rd_valid_w;
    assign stream.rd_data  = rd_data_w;
    assign stream.rd_sop   = rd_sop_w;
    assign stream.rd_eop   = rd_eop_w;

    assign word_cnt = word_cnt_q;
    assign pkt_cnt  = pkt_cnt_q;

endmodule

// File: tb/tb_link_table_queue_ctrl.sv
// Bench for link_table_queue_ctrl: free-table and RAM models around the DUT, a word-queue
// reference model checked every cycle, plus directed scenarios with literal expectations.
module tb_link_table_queue_ctrl;
    localparam int DW = 8;
    localparam int AW = 4;
    localparam int NP = 16;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    link_table_queue_ctrl_if #(.DATA_WIDTH(DW)) bus();

    logic          free_table_read_req, free_table_empty, free_table_write_req;
    logic [AW-1:0] free_table_read_addr, free_table_write_addr;
    logic          ram_wr_en, link_wr_en, ram_rd_en;
    logic [AW-1:0] ram_wr_addr, link_wr_addr, link_wr_data, ram_rd_addr;
    logic [DW:0]   ram_wr_data;
    logic [DW+AW:0] ram_rd_data;
    logic [AW:0]   word_cnt, pkt_cnt;

    link_table_queue_ctrl #(.DATA_WIDTH(DW), .ADDR_PAGE_NUM_LOG(AW)) dut (
        .clk                   (clk),
        .rst_n                 (rst_n),
        .stream                (bus),
        .free_table_read_req   (free_table_read_req),
        .free_table_read_addr  (free_table_read_addr),
        .free_table_empty      (free_table_empty),
        .free_table_write_req  (free_table_write_req),
        .free_table_write_addr (free_table_write_addr),
        .ram_wr_en             (ram_wr_en),
        .ram_wr_addr           (ram_wr_addr),
        .ram_wr_data           (ram_wr_data),
        .link_wr_en            (link_wr_en),
        .link_wr_addr          (link_wr_addr),
        .link_wr_data          (link_wr_data),
        .ram_rd_en             (ram_rd_en),
        .ram_rd_addr           (ram_rd_addr),
        .ram_rd_data           (ram_rd_data),
        .word_cnt              (word_cnt),
        .pkt_cnt               (pkt_cnt)
    );

    // Free table: FIFO of pages, full with 0..NP-1 after reset, pop and push in one cycle.
    logic [AW-1:0] ft_mem [NP];
    int ft_rd, ft_wr, ft_cnt;
    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < NP; i++) ft_mem[i] <= AW'(i);
            ft_rd  <= 0;
            ft_wr  <= 0;
            ft_cnt <= NP;
        end else begin
            if (free_table_read_req && ft_cnt > 0) ft_rd <= (ft_rd + 1) % NP;
            if (free_table_write_req) begin
                ft_mem[ft_wr] <= free_table_write_addr;
                ft_wr <= (ft_wr + 1) % NP;
            end
            ft_cnt <= ft_cnt + (free_table_write_req ? 1 : 0)
                             - ((free_table_read_req && ft_cnt > 0) ? 1 : 0);
        end
    end
    assign free_table_read_addr = ft_mem[ft_rd];
    assign free_table_empty     = (ft_cnt == 0);

    // Data and link RAMs with a synchronous read returning the pre-write contents.
    logic [DW:0]   dram [NP];
    logic [AW-1:0] lram [NP];
    always @(posedge clk) begin
        if (ram_wr_en)  dram[ram_wr_addr]  <= ram_wr_data;
        if (link_wr_en) lram[link_wr_addr] <= link_wr_data;
        if (ram_rd_en)  ram_rd_data <= {dram[ram_rd_addr], lram[ram_rd_addr]};
    end

    typedef struct {
        logic [DW-1:0] data;
        logic          eop;
        logic [AW-1:0] page;
    } word_t;

    word_t exp_q[$];
    bit    exp_sop;
    int    cd;
    int    total = 0;
    int    bad = 0;
    int    cyc = 0;
    int    first_cnt_cyc, first_vld_cyc;
    logic [DW-1:0] out_data[$];
    bit            out_sop[$];
    bit            out_eop[$];
    logic [AW-1:0] freed[$];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    function automatic int pkt_in_q();
        int n = 0;
        foreach (exp_q[i]) if (exp_q[i].eop) n++;
        return n;
    endfunction

    // Reference: a queue of words. Write latency to first output is 4 cycles from an
    // empty queue (3 after the count leaves 0), and 3 cycles between back-to-back words.
    task automatic monitor();
        bit    wf, rf;
        int    sz_rd;
        word_t w;
        if (!rst_n) return;
        if (cd > 0) cd--;
        wf = bus.wr_valid && (ft_cnt != 0);
        rf = bus.rd_valid && bus.rd_ready;
        if (first_cnt_cyc < 0 && word_cnt != 0) first_cnt_cyc = cyc;
        if (first_vld_cyc < 0 && bus.rd_valid)  first_vld_cyc = cyc;

        check("word_cnt", 32'(word_cnt), 32'(exp_q.size()));
        check("pkt_cnt", 32'(pkt_cnt), 32'(pkt_in_q()));
        check("wr_ready", 32'(bus.wr_ready), 32'(ft_cnt != 0));
        check("ft_pop", 32'(free_table_read_req), 32'(wf));
        check("ram_wr_en", 32'(ram_wr_en), 32'(wf));
        check("rd_valid", 32'(bus.rd_valid), 32'(exp_q.size() > 0 && cd == 0));
        check("ft_push", 32'(free_table_write_req), 32'(rf));

        if (bus.rd_valid && exp_q.size() > 0) begin
            check("rd_data", 32'(bus.rd_data), 32'(exp_q[0].data));
            check("rd_eop", 32'(bus.rd_eop), 32'(exp_q[0].eop));
            check("rd_sop", 32'(bus.rd_sop), 32'(exp_sop));
            if (rf) check("ft_push_addr", 32'(free_table_write_addr), 32'(exp_q[0].page));
        end

        sz_rd = exp_q.size() - ((rf && exp_q.size() > 0) ? 1 : 0);
        if (wf) begin
            check("ram_wr_addr", 32'(ram_wr_addr), 32'(free_table_read_addr));
            check("ram_wr_data", 32'(ram_wr_data), 32'({bus.wr_eop, bus.wr_data}));
            check("link_wr_en", 32'(link_wr_en), 32'(sz_rd != 0));
            if (sz_rd != 0 && link_wr_en) begin
                check("link_wr_addr", 32'(link_wr_addr), 32'(exp_q[$].page));
                check("link_wr_data", 32'(link_wr_data), 32'(free_table_read_addr));
            end
        end else begin
            check("link_wr_idle", 32'(link_wr_en), 32'd0);
        end

        if (rf && exp_q.size() > 0) begin
            out_data.push_back(bus.rd_data);
            out_sop.push_back(bus.rd_sop);
            out_eop.push_back(bus.rd_eop);
            freed.push_back(free_table_write_addr);
            exp_sop = exp_q[0].eop;
            void'(exp_q.pop_front());
        end
        if (rf && (sz_rd > 0 || wf))       cd = 3;
        else if (wf && exp_q.size() == 0)  cd = 4;
        if (wf) begin
            w.data = bus.wr_data;
            w.eop  = bus.wr_eop;
            w.page = free_table_read_addr;
            exp_q.push_back(w);
        end
    endtask

    task automatic step(input bit wv, input logic [DW-1:0] wd, input bit we, input bit rr);
        @(negedge clk);
        bus.wr_valid = wv;
        bus.wr_data  = wd;
        bus.wr_eop   = we;
        bus.rd_ready = rr;
        #1;
        monitor();
        cyc++;
    endtask

    task automatic clear_logs();
        out_data.delete();
        out_sop.delete();
        out_eop.delete();
        freed.delete();
        first_cnt_cyc = -1;
        first_vld_cyc = -1;
    endtask

    task automatic do_reset();
        @(negedge clk);
        rst_n        = 1'b0;
        bus.wr_valid = 1'b0;
        bus.wr_data  = '0;
        bus.wr_eop   = 1'b0;
        bus.rd_ready = 1'b0;
        #1;
        check("rst_rd_valid", 32'(bus.rd_valid), 32'd0);
        check("rst_rd_sop", 32'(bus.rd_sop), 32'd0);
        check("rst_word_cnt", 32'(word_cnt), 32'd0);
        check("rst_pkt_cnt", 32'(pkt_cnt), 32'd0);
        check("rst_ft_push", 32'(free_table_write_req), 32'd0);
        check("rst_ram_rd_en", 32'(ram_rd_en), 32'd0);
        exp_q.delete();
        exp_sop = 1'b1;
        cd = 0;
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
    endtask

    task automatic wait_valid(input string name);
        for (int i = 0; i < 12 && !bus.rd_valid; i++) step(1'b0, '0, 1'b0, 1'b0);
        check(name, 32'(bus.rd_valid), 32'd1);
    endtask

    task automatic drain(input string name);
        for (int i = 0; i < 80 && word_cnt != 0; i++) step(1'b0, '0, 1'b0, 1'b1);
        step(1'b0, '0, 1'b0, 1'b0);
        check(name, 32'(word_cnt), 32'd0);
    endtask

    initial begin
        do_reset();

        // Three-word packet out in order, pages 0,1,2 returned, 3-cycle first-word latency.
        clear_logs();
        step(1'b1, 8'hA0, 1'b0, 1'b1);
        step(1'b1, 8'hA1, 1'b0, 1'b1);
        step(1'b1, 8'hA2, 1'b1, 1'b1);
        drain("t1_drain");
        check("t1_n", 32'(out_data.size()), 32'd3);
        if (out_data.size() == 3 && freed.size() == 3) begin
            check("t1_d0", 32'(out_data[0]), 32'hA0);
            check("t1_d1", 32'(out_data[1]), 32'hA1);
            check("t1_d2", 32'(out_data[2]), 32'hA2);
            check("t1_sop", 32'({out_sop[0], out_sop[1], out_sop[2]}), 32'b100);
            check("t1_eop", 32'({out_eop[0], out_eop[1], out_eop[2]}), 32'b001);
            check("t1_freed", 32'({freed[0], freed[1], freed[2]}), 32'h012);
        end
        check("t1_latency", 32'(first_vld_cyc - first_cnt_cyc), 32'd3);

        // Fill every page, then a 17th write must stall.
        do_reset();
        for (int i = 0; i < NP; i++) step(1'b1, 8'(8'h40 + i), (i % 4) == 3, 1'b0);
        step(1'b1, 8'h77, 1'b0, 1'b0);
        check("t2_cnt", 32'(word_cnt), 32'd16);
        check("t2_pkts", 32'(pkt_cnt), 32'd4);
        check("t2_full", 32'(bus.wr_ready), 32'd0);
        check("t2_stall", 32'(free_table_read_req), 32'd0);
        step(1'b1, 8'h78, 1'b0, 1'b0);
        check("t2_cnt_hold", 32'(word_cnt), 32'd16);
        drain("t2_drain");

        // Same-cycle read and write with a single word queued.
        step(1'b1, 8'hB0, 1'b1, 1'b0);
        wait_valid("t3_wait0");
        step(1'b1, 8'hB1, 1'b1, 1'b1);
        step(1'b0, '0, 1'b0, 1'b0);
        check("t3_cnt", 32'(word_cnt), 32'd1);
        wait_valid("t3_wait1");
        check("t3_data", 32'(bus.rd_data), 32'hB1);
        drain("t3_drain");

        // Second word linked while the first is in FETCH, then in LOAD.
        clear_logs();
        step(1'b1, 8'hC0, 1'b0, 1'b0);
        step(1'b0, '0, 1'b0, 1'b0);
        step(1'b1, 8'hC1, 1'b1, 1'b0);
        drain("t4_drain_a");
        step(1'b1, 8'hD0, 1'b0, 1'b0);
        step(1'b0, '0, 1'b0, 1'b0);
        step(1'b0, '0, 1'b0, 1'b0);
        step(1'b1, 8'hD1, 1'b1, 1'b0);
        drain("t4_drain_b");
        check("t4_n", 32'(out_data.size()), 32'd4);
        if (out_data.size() == 4)
            check("t4_seq", {out_data[0], out_data[1], out_data[2], out_data[3]}, 32'hC0C1D0D1);

        // Consumer back-pressure: word held, nothing returned to the free table.
        step(1'b1, 8'hE5, 1'b1, 1'b0);
        wait_valid("t5_wait");
        for (int i = 0; i < 5; i++) begin
            step(1'b0, '0, 1'b0, 1'b0);
            check("t5_hold", 32'(bus.rd_data), 32'hE5);
            check("t5_no_push", 32'(free_table_write_req), 32'd0);
        end
        step(1'b0, '0, 1'b0, 1'b1);
        check("t5_push", 32'(free_table_write_req), 32'd1);
        drain("t5_drain");

        // Randomised traffic with phases of fast, slow and medium consumers.
        for (int i = 0; i < 3000; i++) begin
            int rr_pct;
            rr_pct = ((i / 250) % 3 == 0) ? 80 : (((i / 250) % 3 == 1) ? 20 : 50);
            step($urandom_range(99) < 60, 8'($urandom), $urandom_range(3) == 0,
                 $urandom_range(99) < rr_pct);
        end
        drain("rand_drain");

        // Reset in the middle of a packet, then a fresh packet starts with sop.
        step(1'b1, 8'hF0, 1'b0, 1'b0);
        step(1'b1, 8'hF1, 1'b0, 1'b0);
        step(1'b1, 8'hF2, 1'b0, 1'b0);
        step(1'b0, '0, 1'b0, 1'b0);
        do_reset();
        step(1'b1, 8'h11, 1'b0, 1'b0);
        step(1'b1, 8'h12, 1'b1, 1'b0);
        wait_valid("t6_wait");
        check("t6_sop", 32'(bus.rd_sop), 32'd1);
        check("t6_data", 32'(bus.rd_data), 32'h11);
        drain("t6_drain");

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
